inst_loader: RTL and testbench

//   Write side of instruction memory: accepts a program as a stream of DW-bit

---
 rtl/inst_loader_pkg.sv | 17 +
 rtl/inst_ram.sv | 29 ++
 rtl/inst_loader.sv | 117 +++++++++++
 tb/tb_inst_loader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// Shared types and defaults for the instruction loader.
//   IW_DEF : default address width (storage depth 2**IW_DEF words)
//   DW_DEF : default instruction word width
//   state_t: loader FSM states
package inst_loader_pkg;

   localparam int IW_DEF = 16;
   localparam int DW_DEF = 9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/inst_ram.sv
// Instruction storage: 2**IW x DW words, one synchronous write port and one
// combinational read port. Contents are never reset.
//   clk_i   : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : mem[raddr_i], combinational (old data on the write edge cycle)
module inst_ram #(
   parameter int IW = 16,
   parameter int DW = 9
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [IW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [IW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem [2**IW];

   always_ff @(posedge clk_i) begin
      if (we_i) mem[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/inst_loader.sv
// Instruction loader: streams a program over a valid/ready handshake into
// instruction storage starting at BaseAddr, then checks a trailing XOR
// checksum word. Also exposes the core's combinational fetch port.
//   CLK, Reset        : clock, async active-high reset
//   Start             : begin a load (honoured in IDLE or DONE only)
//   BaseAddr, LoadLen : first write address and program length, latched on Start
//   WrData/WrValid/WrReady : program word / checksum stream
//   InstAddress/InstOut    : fetch port, InstOut = mem[InstAddress]
//   Busy, Done, CsumErr, WordCount : load status
module inst_loader
   import inst_loader_pkg::*;
#(
   parameter int IW = IW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          CLK,
   input  logic          Reset,
   input  logic          Start,
   input  logic [IW-1:0] BaseAddr,
   input  logic [IW-1:0] LoadLen,
   input  logic [DW-1:0] WrData,
   input  logic          WrValid,
   output logic          WrReady,
   input  logic [IW-1:0] InstAddress,
   output logic [DW-1:0] InstOut,
   output logic          Busy,
   output logic          Done,
   output logic          CsumErr,
   output logic [IW-1:0] WordCount
);

   localparam logic [IW-1:0] ONE = IW'(1);

   state_t        state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] len_q, len_d;
   logic [IW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] csum_q, csum_d;
   logic          err_q, err_d;
   logic          we;
   logic          xfer;

   assign WrReady   = (state_q == LOAD) || (state_q == CHECK);
   assign Busy      = WrReady;
   assign Done      = (state_q == DONE);
   assign CsumErr   = err_q;
   assign WordCount = cnt_q;
   assign xfer      = WrValid && WrReady;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      csum_d  = csum_q;
      err_d   = err_q;
      we      = 1'b0;
      unique case (state_q)
         // DONE behaves like IDLE for Start so a new load can begin back-to-back
         IDLE, DONE: begin
            if (Start) begin
               ptr_d   = BaseAddr;
               len_d   = LoadLen;
               cnt_d   = '0;
               csum_d  = '0;
               err_d   = 1'b0;
               state_d = (LoadLen != '0) ? LOAD : CHECK;
            end
         end
         LOAD: begin
            if (xfer) begin
               we     = 1'b1;
               ptr_d  = ptr_q + ONE;   // wraps mod 2**IW
               csum_d = csum_q ^ WrData;
               cnt_d  = cnt_q + ONE;
               if (cnt_q == len_q - ONE) state_d = CHECK;
            end
         end
         CHECK: begin
            // checksum word is compared only, never stored
            if (xfer) begin
               err_d   = (WrData != csum_q);
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         csum_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         csum_q  <= csum_d;
         err_q   <= err_d;
      end
   end

   inst_ram #(.IW(IW), .DW(DW)) u_ram (
      .clk_i   (CLK),
      .we_i    (we),
      .waddr_i (ptr_q),
      .wdata_i (WrData),
      .raddr_i (InstAddress),
      .rdata_o (InstOut)
   );

endmodule

// File: tb/tb_inst_loader.sv
module tb_inst_loader;

   localparam int IW = 16;
   localparam int DW = 9;

   logic          CLK = 1'b0;
   logic          Reset, Start, WrValid, WrReady, Busy, Done, CsumErr;
   logic [IW-1:0] BaseAddr, LoadLen, InstAddress, WordCount;
   logic [DW-1:0] WrData, InstOut;

   // small instance for address wrap
   logic          Start4, WrValid4, WrReady4, Busy4, Done4, Err4;
   logic [3:0]    Base4, Len4, Addr4, Cnt4;
   logic [DW-1:0] WrData4, Out4;

   always #5 CLK = ~CLK;

   inst_loader #(.IW(IW), .DW(DW)) dut (
      .CLK(CLK), .Reset(Reset), .Start(Start), .BaseAddr(BaseAddr), .LoadLen(LoadLen),
      .WrData(WrData), .WrValid(WrValid), .WrReady(WrReady), .InstAddress(InstAddress),
      .InstOut(InstOut), .Busy(Busy), .Done(Done), .CsumErr(CsumErr), .WordCount(WordCount)
   );

   inst_loader #(.IW(4), .DW(DW)) dut4 (
      .CLK(CLK), .Reset(Reset), .Start(Start4), .BaseAddr(Base4), .LoadLen(Len4),
      .WrData(WrData4), .WrValid(WrValid4), .WrReady(WrReady4), .InstAddress(Addr4),
      .InstOut(Out4), .Busy(Busy4), .Done(Done4), .CsumErr(Err4), .WordCount(Cnt4)
   );

   typedef struct {
      logic [IW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] prog [0:7];
   int            checks = 0;
   int            passes = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Entered and left just after a rising edge.
   task automatic send(input logic [DW-1:0] w);
      bit ok;
      ok      = 1'b0;
      WrData  = w;
      WrValid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge CLK);
         if (WrReady === 1'b1) ok = 1'b1;
         @(posedge CLK); #1;
      end
      WrValid = 1'b0;
      if (!ok) begin
         checks++;
         $error("FAIL handshake_timeout observed=WrReady low expected=WrReady high");
      end
   endtask

   task automatic do_start(input logic [IW-1:0] base, input logic [IW-1:0] len);
      Start = 1'b1; BaseAddr = base; LoadLen = len;
      @(posedge CLK); #1;
      Start = 1'b0;
   endtask

   task automatic run_load(input logic [IW-1:0] base, input int len,
                           input logic [DW-1:0] csum, input bit gap);
      do_start(base, IW'(len));
      for (int i = 0; i < len; i++) begin
         sb.push_back('{addr: base + IW'(i), data: prog[i]});
         send(prog[i]);
         if (gap) begin
            @(posedge CLK); #1;
         end
      end
      send(csum);
   endtask

   task automatic check_sb(input string tag);
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         InstAddress = e.addr;
         #1 chk(tag, 32'(InstOut), 32'(e.data));
      end
      @(posedge CLK); #1;
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b0; WrValid = 1'b0; WrData = '0;
      BaseAddr = '0; LoadLen = '0; InstAddress = '0;
      Start4 = 1'b0; WrValid4 = 1'b0; WrData4 = '0; Base4 = '0; Len4 = '0; Addr4 = '0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_wrready", 32'(WrReady), 32'd0);
      chk("rst_busy",    32'(Busy),    32'd0);
      chk("rst_done",    32'(Done),    32'd0);
      chk("rst_csumerr", 32'(CsumErr), 32'd0);
      chk("rst_count",   32'(WordCount), 32'd0);
      Reset = 1'b0;
      @(posedge CLK); #1;

      // 1: basic load, good checksum
      prog[0] = 9'h001; prog[1] = 9'h0A5; prog[2] = 9'h1FF;
      run_load(16'h0000, 3, 9'h15B, 1'b0);
      chk("t1_done",  32'(Done),      32'd1);
      chk("t1_err",   32'(CsumErr),   32'd0);
      chk("t1_count", 32'(WordCount), 32'd3);
      check_sb("t1_mem");

      // 2: bad checksum, words still stored
      run_load(16'h0010, 3, 9'h000, 1'b0);
      chk("t2_done",  32'(Done),    32'd1);
      chk("t2_err",   32'(CsumErr), 32'd1);
      check_sb("t2_mem");

      // 3: sender inserts idle cycles between words
      run_load(16'h0020, 3, 9'h15B, 1'b1);
      chk("t3_done",  32'(Done),      32'd1);
      chk("t3_err",   32'(CsumErr),   32'd0);
      chk("t3_count", 32'(WordCount), 32'd3);
      check_sb("t3_mem");
      InstAddress = 16'h0023;
      #1 chk("t3_no_extra", 32'(InstOut === 9'h1FF), 32'd0);

      // 4: write pointer wraps in a 16-word store
      Start4 = 1'b1; Base4 = 4'd15; Len4 = 4'd2;
      @(posedge CLK); #1;
      Start4 = 1'b0;
      chk("t4_ready", 32'(WrReady4), 32'd1);
      WrData4 = 9'h0AA; WrValid4 = 1'b1;
      @(posedge CLK); #1;
      WrData4 = 9'h055;
      @(posedge CLK); #1;
      chk("t4_busy_check", 32'(Busy4 && !Done4), 32'd1);
      WrData4 = 9'h0FF;
      @(posedge CLK); #1;
      WrValid4 = 1'b0;
      chk("t4_done",  32'(Done4), 32'd1);
      chk("t4_err",   32'(Err4),  32'd0);
      chk("t4_count", 32'(Cnt4),  32'd2);
      Addr4 = 4'd15;
      #1 chk("t4_mem15", 32'(Out4), 32'h0AA);
      Addr4 = 4'd0;
      #1 chk("t4_mem0",  32'(Out4), 32'h055);
      @(posedge CLK); #1;

      // 6a: zero-length load, checksum only
      do_start(16'h0000, 16'h0000);
      chk("t6_busy", 32'(Busy), 32'd1);
      send(9'h000);
      chk("t6_done",  32'(Done),      32'd1);
      chk("t6_err",   32'(CsumErr),   32'd0);
      chk("t6_count", 32'(WordCount), 32'd0);
      InstAddress = 16'h0000;
      #1 chk("t6_no_write", 32'(InstOut), 32'h001);
      @(posedge CLK); #1;

      // 7: fetch of the address being written shows old data until the edge
      do_start(16'h0000, 16'h0002);
      InstAddress = 16'h0000;
      WrData = 9'h111; WrValid = 1'b1;
      @(negedge CLK);
      chk("t7_old_data", 32'(InstOut), 32'h001);
      @(posedge CLK); #1;
      WrValid = 1'b0;
      chk("t7_new_data", 32'(InstOut), 32'h111);
      send(9'h022);
      send(9'h133);
      chk("t7_done", 32'(Done),    32'd1);
      chk("t7_err",  32'(CsumErr), 32'd0);
      sb.push_back('{addr: 16'h0001, data: 9'h022});
      check_sb("t7_mem");

      // 5: reset mid-load
      do_start(16'h0040, 16'h0003);
      send(9'h0C3);
      Reset = 1'b1;
      #1;
      chk("t5_busy",  32'(Busy),    32'd0);
      chk("t5_ready", 32'(WrReady), 32'd0);
      chk("t5_done",  32'(Done),    32'd0);
      InstAddress = 16'h0040;
      #1 chk("t5_kept", 32'(InstOut), 32'h0C3);
      @(posedge CLK); #1;
      Reset = 1'b0;
      @(posedge CLK); #1;
      prog[0] = 9'h1C0; prog[1] = 9'h003; prog[2] = 9'h050;
      run_load(16'h0040, 3, 9'h193, 1'b0);
      chk("t5_reload_done", 32'(Done),    32'd1);
      chk("t5_reload_err",  32'(CsumErr), 32'd0);
      check_sb("t5_reload_mem");

      // 6b: Start during LOAD is ignored
      prog[0] = 9'h101; prog[1] = 9'h0F0; prog[2] = 9'h00F;
      do_start(16'h0060, 16'h0003);
      sb.push_back('{addr: 16'h0060, data: prog[0]});
      send(prog[0]);
      Start = 1'b1; BaseAddr = 16'h0070; LoadLen = 16'h0005;
      @(posedge CLK); #1;
      Start = 1'b0;
      sb.push_back('{addr: 16'h0061, data: prog[1]});
      send(prog[1]);
      sb.push_back('{addr: 16'h0062, data: prog[2]});
      send(prog[2]);
      send(9'h1FE);
      chk("t6b_done",  32'(Done),      32'd1);
      chk("t6b_err",   32'(CsumErr),   32'd0);
      chk("t6b_count", 32'(WordCount), 32'd3);
      check_sb("t6b_mem");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
